clk_div_gen: RTL and testbench

CLK_DIV_GEN -- requirements
Module: clk_div_gen

---
 rtl/clk_div_gen_pkg.sv | 16 +
 rtl/clk_div_gen_if.sv | 15 +
 rtl/clk_div_gen_chan.sv | 117 +++++++++++
 rtl/clk_div_gen.sv | 60 ++++++
 tb/tb_clk_div_gen.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_gen_pkg.sv
// Shared defaults and controller state type for the clk_div_gen divider family.
package clk_div_pkg;

    localparam int unsigned DEF_NUM_CH = 3;
    localparam int unsigned DEF_CNT_W  = 8;
    localparam int unsigned DEF_PH_W   = 6;

    // ch0 (ser) = 16, ch1 (enc) = 8, ch2 (fsm) = 2; ch0 occupies the LSBs
    localparam logic [DEF_NUM_CH*DEF_CNT_W-1:0] DEF_HALF_RST = {8'd2, 8'd8, 8'd16};

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } chan_state_e;

endpackage

// File: rtl/clk_div_gen_if.sv
// Configuration port of clk_div_gen: per-channel half-period/stretch load with busy/error status.
interface clk_div_gen_if #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned PH_W   = 6
);
    logic [NUM_CH*CNT_W-1:0] cfg_half;
    logic [NUM_CH*PH_W-1:0]  cfg_per;
    logic                    cfg_load;
    logic                    cfg_busy;
    logic                    cfg_err;

    modport master (output cfg_half, cfg_per, cfg_load, input cfg_busy, cfg_err);
    modport slave  (input cfg_half, cfg_per, cfg_load, output cfg_busy, cfg_err);
endinterface

// File: rtl/clk_div_gen_chan.sv
// One divided-clock channel: half-period counter plus RUN/PEND handover of shadow config.
// Fractional stretch (phase counter) is compiled in only with CLK_DIV_GEN_FRAC_EN.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned      CNT_W = DEF_CNT_W,
`ifdef CLK_DIV_GEN_FRAC_EN
    parameter int unsigned      PH_W  = DEF_PH_W,
`endif
    parameter logic [CNT_W-1:0] DEF_H = '0
) (
    input  logic             local_clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_half,
`ifdef CLK_DIV_GEN_FRAC_EN
    input  logic [PH_W-1:0]  i_per,
`endif
    output logic             o_clk,
    output logic             o_tick,
    output logic             o_pend
);

    chan_state_e      r_state;
    chan_state_e      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_act_h;
    logic [CNT_W-1:0] r_sh_h;
    logic             r_clk;
    logic             r_tick;
    logic [CNT_W:0]   w_len;
    logic             w_end;
    logic             w_apply;

`ifdef CLK_DIV_GEN_FRAC_EN
    logic [PH_W-1:0]  r_phase;
    logic [PH_W-1:0]  r_act_p;
    logic [PH_W-1:0]  r_sh_p;
    logic             w_stretch;

    assign w_stretch = (r_act_p != '0) && (r_phase == r_act_p - PH_W'(1));
    assign w_len     = {1'b0, r_act_h} + {{CNT_W{1'b0}}, w_stretch};
`else
    assign w_len     = {1'b0, r_act_h};
`endif

    // w_len is at least 1 whenever r_act_h is nonzero, so the subtraction cannot wrap
    assign w_end   = (r_act_h != '0) && ({1'b0, r_cnt} == w_len - (CNT_W+1)'(1));
    assign w_apply = (r_state == PEND) &&
                     ((w_end && r_clk) || (!r_clk && (r_act_h == '0)));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (i_load)  w_state_nxt = PEND;
            PEND:    if (w_apply) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_act_h <= DEF_H;
            r_sh_h  <= '0;
            r_clk   <= 1'b0;
            r_tick  <= 1'b0;
`ifdef CLK_DIV_GEN_FRAC_EN
            r_phase <= '0;
            r_act_p <= '0;
            r_sh_p  <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= 1'b0;
            if (i_load) begin
                r_sh_h <= i_half;
`ifdef CLK_DIV_GEN_FRAC_EN
                r_sh_p <= i_per;
`endif
            end
            // Handover lands on a falling toggle, so the new H starts a fresh low half-period
            if (w_apply) begin
                r_act_h <= r_sh_h;
                r_cnt   <= '0;
                r_clk   <= 1'b0;
`ifdef CLK_DIV_GEN_FRAC_EN
                r_act_p <= r_sh_p;
                r_phase <= '0;
`endif
            end else if (r_act_h == '0) begin
                r_cnt   <= '0;
                r_clk   <= 1'b0;
`ifdef CLK_DIV_GEN_FRAC_EN
                r_phase <= '0;
`endif
            end else if (w_end) begin
                r_cnt   <= '0;
                r_clk   <= ~r_clk;
                r_tick  <= ~r_clk;
`ifdef CLK_DIV_GEN_FRAC_EN
                if (r_act_p == '0) r_phase <= '0;
                else if (w_stretch) r_phase <= '0;
                else r_phase <= r_phase + PH_W'(1);
`endif
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_clk  = r_clk;
    assign o_tick = r_tick;
    assign o_pend = (r_state == PEND);

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel clock divider: NUM_CH clk_div_chan instances plus shared cfg_busy/cfg_err.
// Define CLK_DIV_GEN_FRAC_EN to enable per-channel fractional half-period stretch.
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int unsigned             NUM_CH   = DEF_NUM_CH,
    parameter int unsigned             CNT_W    = DEF_CNT_W,
    parameter int unsigned             PH_W     = DEF_PH_W,
    parameter logic [NUM_CH*CNT_W-1:0] DEF_HALF = DEF_HALF_RST
) (
    input  logic              local_clk,
    input  logic              rst,
    clk_div_gen_if.slave      cfg,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick_rise
);

    logic [NUM_CH-1:0] w_pend;
    logic              w_accept;
    logic              r_busy;
    logic              r_err;

    assign w_accept = cfg.cfg_load && !r_busy;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_chan #(
            .CNT_W (CNT_W),
`ifdef CLK_DIV_GEN_FRAC_EN
            .PH_W  (PH_W),
`endif
            .DEF_H (DEF_HALF[g*CNT_W +: CNT_W])
        ) u_chan (
            .local_clk (local_clk),
            .rst       (rst),
            .i_load    (w_accept),
            .i_half    (cfg.cfg_half[g*CNT_W +: CNT_W]),
`ifdef CLK_DIV_GEN_FRAC_EN
            .i_per     (cfg.cfg_per[g*PH_W +: PH_W]),
`endif
            .o_clk     (clk_out[g]),
            .o_tick    (tick_rise[g]),
            .o_pend    (w_pend[g])
        );
    end

    // Busy uses the pre-edge pending flags, so it drops one cycle after the last handover
    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) begin
            r_busy <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= w_accept || (|w_pend);
            r_err  <= cfg.cfg_load && r_busy;
        end
    end

    assign cfg.cfg_busy = r_busy;
    assign cfg.cfg_err  = r_err;

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: closed-form reference model checked every cycle,
// a table of period vectors, and directed handover/reject/stretch/reset sequences.
module tb_clk_div_gen;
    import clk_div_pkg::*;

`ifdef CLK_DIV_GEN_FRAC_EN
    localparam bit FRAC = 1'b1;
`else
    localparam bit FRAC = 1'b0;
`endif

    logic       local_clk = 1'b0;
    logic       rst;
    logic [2:0] clk_out;
    logic [2:0] tick_rise;

    clk_div_gen_if #(.NUM_CH(3), .CNT_W(8), .PH_W(6)) cfg_if ();

    clk_div_gen #(.NUM_CH(3), .CNT_W(8), .PH_W(6)) dut (
        .local_clk (local_clk),
        .rst       (rst),
        .cfg       (cfg_if),
        .clk_out   (clk_out),
        .tick_rise (tick_rise)
    );

    always #5 local_clk = ~local_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: each channel is a segment that began with clk low at an
    // edge count of zero; its level follows from how many half-periods fit.
    int unsigned m_h [3];
    int unsigned m_p [3];
    int unsigned m_e [3];
    int unsigned m_sh_h [3];
    int unsigned m_sh_p [3];
    bit          m_pend [3];
    bit          m_busy;
    bit          m_err;
    logic [2:0]  m_clk;
    logic [2:0]  m_tick;

    typedef struct {
        logic [23:0] half;
        int unsigned exp0;
        int unsigned exp1;
        int unsigned exp2;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned halves_done(int unsigned e, int unsigned h, int unsigned p);
        int unsigned blk, r, c2;
        if (p == 0) return e / h;
        blk = p * h + 1;
        r   = e % blk;
        c2  = r / h;
        if (c2 > p - 1) c2 = p - 1;
        return (e / blk) * p + c2;
    endfunction

    function automatic int unsigned span(int unsigned c, int unsigned h, int unsigned p);
        return c * h + ((p == 0) ? 0 : c / p);
    endfunction

    task automatic model_reset();
        m_h[0] = 16; m_h[1] = 8; m_h[2] = 2;
        for (int c = 0; c < 3; c++) begin
            m_p[c] = 0; m_e[c] = 0; m_pend[c] = 0; m_sh_h[c] = 0; m_sh_p[c] = 0;
        end
        m_busy = 0; m_err = 0; m_clk = '0; m_tick = '0;
    endtask

    task automatic model_edge();
        bit any_pend;
        bit accept;
        any_pend = 0;
        for (int c = 0; c < 3; c++) any_pend |= m_pend[c];
        for (int c = 0; c < 3; c++) begin
            int unsigned e, n;
            bit lvl, rise, fall;
            e = m_e[c] + 1; lvl = 0; rise = 0; fall = 0;
            if (m_h[c] != 0) begin
                n   = halves_done(e, m_h[c], m_p[c]);
                lvl = n[0];
                if (n > 0 && span(n, m_h[c], m_p[c]) == e) begin
                    rise = n[0];
                    fall = !n[0];
                end
            end
            if (m_pend[c] && (fall || m_h[c] == 0)) begin
                m_h[c] = m_sh_h[c]; m_p[c] = m_sh_p[c];
                m_e[c] = 0; m_pend[c] = 0; lvl = 0; rise = 0;
            end else begin
                m_e[c] = (m_h[c] == 0) ? 0 : e;
            end
            m_clk[c]  = lvl;
            m_tick[c] = rise;
        end
        m_err  = cfg_if.cfg_load && m_busy;
        accept = cfg_if.cfg_load && !m_busy;
        m_busy = accept || any_pend;
        if (accept) begin
            for (int c = 0; c < 3; c++) begin
                m_sh_h[c] = cfg_if.cfg_half[c*8 +: 8];
                m_sh_p[c] = FRAC ? int'(cfg_if.cfg_per[c*6 +: 6]) : 0;
                m_pend[c] = 1;
            end
        end
    endtask

    task automatic step();
        @(posedge local_clk);
        model_edge();
        #1;
        check("clk_out", 32'(clk_out), 32'(m_clk));
        check("tick_rise", 32'(tick_rise), 32'(m_tick));
        check("cfg_busy", 32'(cfg_if.cfg_busy), 32'(m_busy));
        check("cfg_err", 32'(cfg_if.cfg_err), 32'(m_err));
    endtask

    task automatic wait_busy_low(input int unsigned budget);
        int unsigned k;
        k = 0;
        while (cfg_if.cfg_busy !== 1'b0 && k < budget) begin
            step();
            k++;
        end
        check("busy_clear", 32'(cfg_if.cfg_busy), 32'd0);
    endtask

    task automatic load_cfg(input logic [23:0] half, input logic [17:0] per);
        cfg_if.cfg_half = half;
        cfg_if.cfg_per  = per;
        cfg_if.cfg_load = 1'b1;
        step();
        cfg_if.cfg_load = 1'b0;
    endtask

    task automatic measure(output int unsigned p0, output int unsigned p1, output int unsigned p2);
        int unsigned first [3];
        int unsigned cnt [3];
        int unsigned per [3];
        for (int c = 0; c < 3; c++) begin first[c] = 0; cnt[c] = 0; per[c] = 0; end
        for (int t = 0; t < 150; t++) begin
            step();
            for (int c = 0; c < 3; c++) begin
                if (tick_rise[c]) begin
                    if (cnt[c] == 0) first[c] = t;
                    else if (cnt[c] == 1) per[c] = t - first[c];
                    cnt[c]++;
                end
            end
        end
        for (int c = 0; c < 3; c++) if (cnt[c] == 1) per[c] = 9999;
        p0 = per[0]; p1 = per[1]; p2 = per[2];
    endtask

    task automatic check_reset_outputs();
        check("rst_clk_out", 32'(clk_out), 32'd0);
        check("rst_tick_rise", 32'(tick_rise), 32'd0);
        check("rst_cfg_busy", 32'(cfg_if.cfg_busy), 32'd0);
        check("rst_cfg_err", 32'(cfg_if.cfg_err), 32'd0);
    endtask

    task automatic release_and_check_first_rise();
        @(posedge local_clk);
        @(posedge local_clk);
        #3 rst = 1'b1;
        model_reset();
        step();
        check("ch2_low_edge1", 32'(clk_out[2]), 32'd0);
        step();
        check("ch2_rise_edge2", 32'(clk_out[2]), 32'd1);
        check("ch2_tick_edge2", 32'(tick_rise[2]), 32'd1);
    endtask

    initial begin
        vec_t        tbl [5];
        int unsigned p0, p1, p2, k, nl, lastt, bad;
        int          first5;
        int unsigned lens [70];
        logic        prev;
        bit          first_ok;

        tbl[0] = '{half: {8'd2, 8'd8, 8'd16}, exp0: 32, exp1: 16, exp2: 4};
        tbl[1] = '{half: {8'd1, 8'd0, 8'd3},  exp0: 6,  exp1: 0,  exp2: 2};
        tbl[2] = '{half: {8'd5, 8'd7, 8'd1},  exp0: 2,  exp1: 14, exp2: 10};
        tbl[3] = '{half: {8'd0, 8'd1, 8'd9},  exp0: 18, exp1: 2,  exp2: 0};
        tbl[4] = '{half: {8'd4, 8'd2, 8'd6},  exp0: 12, exp1: 4,  exp2: 8};

        cfg_if.cfg_half = '0;
        cfg_if.cfg_per  = '0;
        cfg_if.cfg_load = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1 check_reset_outputs();
        model_reset();
        release_and_check_first_rise();

        measure(p0, p1, p2);
        check("def_period_ch0", p0, 32);
        check("def_period_ch1", p1, 16);
        check("def_period_ch2", p2, 4);

        for (int i = 0; i < 5; i++) begin
            wait_busy_low(300);
            load_cfg(tbl[i].half, '0);
            check("load_sets_busy", 32'(cfg_if.cfg_busy), 32'd1);
            wait_busy_low(300);
            measure(p0, p1, p2);
            check("tbl_period_ch0", p0, tbl[i].exp0);
            check("tbl_period_ch1", p1, tbl[i].exp1);
            check("tbl_period_ch2", p2, tbl[i].exp2);
        end

        // Shorten ch0 mid-high, then try a rejected second load
        wait_busy_low(300);
        load_cfg({8'd2, 8'd8, 8'd16}, '0);
        wait_busy_low(300);
        k = 0;
        while (clk_out[0] !== 1'b1 && k < 80) begin step(); k++; end
        check("ch0_high_found", 32'(clk_out[0]), 32'd1);
        load_cfg({8'd2, 8'd8, 8'd3}, '0);
        check("ch0_still_high", 32'(clk_out[0]), 32'd1);
        load_cfg({8'd1, 8'd1, 8'd1}, '0);
        check("err_pulse", 32'(cfg_if.cfg_err), 32'd1);
        step();
        check("err_one_cycle", 32'(cfg_if.cfg_err), 32'd0);
        k = 0;
        while (clk_out[0] !== 1'b0 && k < 40) begin step(); k++; end
        check("ch0_fell", 32'(clk_out[0]), 32'd0);
        k = 0;
        while (clk_out[0] !== 1'b1 && k < 40) begin step(); k++; end
        check("ch0_new_low_len", k, 3);
        wait_busy_low(300);
        measure(p0, p1, p2);
        check("after_err_ch0", p0, 6);
        check("after_err_ch1", p1, 16);
        check("after_err_ch2", p2, 4);

        // ch2 H=4 with stretch period 32
        load_cfg({8'd4, 8'd0, 8'd0}, {6'd32, 6'd0, 6'd0});
        wait_busy_low(300);
        nl = 0; lastt = 0; first_ok = 0; prev = clk_out[2];
        for (int t = 0; t < 400 && nl < 70; t++) begin
            step();
            if (clk_out[2] !== prev) begin
                if (first_ok) begin lens[nl] = t - lastt; nl++; end
                first_ok = 1; lastt = t; prev = clk_out[2];
            end
        end
        check("stretch_count", nl, 70);
        first5 = -1; bad = 0;
        for (int j = 0; j < int'(nl); j++) if (lens[j] == 5 && first5 < 0) first5 = j;
        for (int j = 0; j < int'(nl); j++) begin
            int unsigned ex;
            ex = (FRAC && first5 >= 0 && j >= first5 && (j - first5) % 32 == 0) ? 5 : 4;
            if (lens[j] != ex) bad++;
        end
        check("stretch_pattern_bad", bad, 0);
        first_ok = FRAC ? (first5 >= 0 && first5 < 32) : (first5 < 0);
        check("stretch_first5", 32'(first_ok), 32'd1);

        for (int i = 0; i < 2500; i++) begin
            cfg_if.cfg_half = {8'($urandom_range(0, 9)), 8'($urandom_range(0, 9)), 8'($urandom_range(0, 9))};
            cfg_if.cfg_per  = {6'($urandom_range(0, 5)), 6'($urandom_range(0, 5)), 6'($urandom_range(0, 5))};
            cfg_if.cfg_load = ($urandom_range(0, 24) == 0);
            step();
        end
        cfg_if.cfg_load = 1'b0;

        // Reset while ch0 is high and a config is pending
        wait_busy_low(300);
        load_cfg({8'd2, 8'd8, 8'd16}, '0);
        wait_busy_low(300);
        k = 0;
        while (clk_out[0] !== 1'b1 && k < 80) begin step(); k++; end
        load_cfg({8'd1, 8'd1, 8'd1}, '0);
        check("pre_rst_high", 32'(clk_out[0]), 32'd1);
        check("pre_rst_busy", 32'(cfg_if.cfg_busy), 32'd1);
        #2 rst = 1'b0;
        #1 check_reset_outputs();
        release_and_check_first_rise();
        measure(p0, p1, p2);
        check("post_rst_ch0", p0, 32);
        check("post_rst_ch1", p1, 16);
        check("post_rst_ch2", p2, 4);
        check("post_rst_idle", 32'(cfg_if.cfg_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
